// File: rtl/sprite_pkg.sv
// Shared widths and descriptor layout for the sprite shift chain.
package sprite_pkg;

  localparam int POS_W = 9;
  localparam int SCL_W = 4;
  localparam int COL_W = 5;
  localparam int NCOL  = 4;
  localparam int PIX_W = 32;

  localparam int ENTRY_W = 1 + SCL_W + POS_W + NCOL*COL_W + PIX_W;

  // Descriptor fields, MSB first: swpX, sclX, posX, bcolor, colors.
  typedef struct packed {
    logic                    swpX;
    logic [SCL_W-1:0]        sclX;
    logic [POS_W-1:0]        posX;
    logic [NCOL*COL_W-1:0]   bcolor;
    logic [PIX_W-1:0]        colors;
  } desc_t;

  function automatic logic [ENTRY_W-1:0] pack_desc(input desc_t d);
    return d;
  endfunction

  function automatic desc_t unpack_desc(input logic [ENTRY_W-1:0] v);
    return desc_t'(v);
  endfunction

endpackage

// File: rtl/sprite_shift_slot.sv
// One descriptor slot: valid bit plus payload, with
// clear > load-from-input > load-from-neighbour > hold priority.
module sprite_shift_slot
  import sprite_pkg::*;
#(
  parameter int W = ENTRY_W + 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ld_in,
  input  logic         ld_nb,
  input  logic [W-1:0] d_in,
  input  logic [W-1:0] d_nb,
  output logic [W-1:0] q
);

  // Prioritised slot update; clear zeroes both valid and payload.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (ld_in) begin
      q <= d_in;
    end else if (ld_nb) begin
      q <= d_nb;
    end
  end

endmodule

// File: rtl/sprite_shift_chain.sv
// Ordered queue of sprite descriptors: fetch pushes at the tail,
// the renderer reads and pops slot 0, rotate recycles the head.
module sprite_shift_chain
  import sprite_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int POS_W = sprite_pkg::POS_W,
  parameter int SCL_W = sprite_pkg::SCL_W,
  parameter int COL_W = sprite_pkg::COL_W,
  parameter int NCOL  = sprite_pkg::NCOL,
  parameter int PIX_W = sprite_pkg::PIX_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       rot,
  input  logic [POS_W-1:0]           i_posX,
  input  logic [SCL_W-1:0]           i_sclX,
  input  logic                       i_swpX,
  input  logic [NCOL*COL_W-1:0]      i_bcolor,
  input  logic [PIX_W-1:0]           i_colors,
  output logic                       push_ready,
  output logic                       o_valid,
  output logic [POS_W-1:0]           o_posX,
  output logic [SCL_W-1:0]           o_sclX,
  output logic                       o_swpX,
  output logic [NCOL*COL_W-1:0]      o_bcolor,
  output logic [PIX_W-1:0]           o_colors,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = 1 + SCL_W + POS_W + NCOL*COL_W + PIX_W;
  localparam int SW = EW + 1;

  logic [SW-1:0] slot_q [DEPTH];
  logic [SW-1:0] in_entry;
  logic          flush;
  logic          rot_eff;
  logic          pop_eff;
  logic          push_acc;
  logic          shift;
  logic [CW-1:0] wr_idx;
  logic [CW-1:0] last_idx;

  assign flush    = rst || clr;
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

  // Rotate takes precedence over pop/push; pop on empty is a no-op.
  assign rot_eff  = rot && !empty;
  assign pop_eff  = pop && !empty && !rot;
  assign push_ready = (!full || (pop && !rot)) && !rot;
  assign push_acc = push && push_ready;
  assign shift    = rot_eff || pop_eff;

  // When popping, the tail moves down one, so the write lands one lower.
  assign wr_idx   = count - CW'(pop_eff);
  assign last_idx = count - CW'(1);

  assign in_entry = {1'b1, i_swpX, i_sclX, i_posX, i_bcolor, i_colors};

  // Head outputs are straight from slot 0 registers.
  assign o_valid = slot_q[0][EW];
  assign {o_swpX, o_sclX, o_posX, o_bcolor, o_colors} = slot_q[0][EW-1:0];

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    localparam logic [CW-1:0] IDX = CW'(i);
    logic          ld_in;
    logic [SW-1:0] d_in;
    logic [SW-1:0] d_nb;

    if (i == DEPTH-1) begin : g_tail
      assign d_nb = '0;
    end else begin : g_body
      assign d_nb = slot_q[i+1];
    end

    // Per-slot direct load: recycled head on rotate, or the pushed entry.
    always_comb begin
      ld_in = 1'b0;
      d_in  = in_entry;
      if (rot_eff) begin
        if (IDX == last_idx) begin
          ld_in = 1'b1;
          d_in  = slot_q[0];
        end
      end else if (push_acc && (IDX == wr_idx)) begin
        ld_in = 1'b1;
      end
    end

    sprite_shift_slot #(.W(SW)) u_slot (
      .clk   (clk),
      .clr   (flush),
      .ld_in (ld_in),
      .ld_nb (shift),
      .d_in  (d_in),
      .d_nb  (d_nb),
      .q     (slot_q[i])
    );
  end

  // Occupancy: +1 on accepted push, -1 on effective pop, unchanged on rotate.
  always_ff @(posedge clk) begin
    if (flush) begin
      count <= '0;
    end else if (push_acc && !pop_eff) begin
      count <= count + CW'(1);
    end else if (pop_eff && !push_acc) begin
      count <= count - CW'(1);
    end
  end

  // Sticky record of any push that was not accepted.
  always_ff @(posedge clk) begin
    if (flush) begin
      overflow <= 1'b0;
    end else if (push && !push_ready) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sprite_shift_chain.sv
// Directed bench for sprite_shift_chain (default parameters).
module tb_sprite_shift_chain;
  import sprite_pkg::*;

  logic        clk = 1'b0;
  logic        rst, clr, push, pop, rot;
  logic [8:0]  i_posX;
  logic [3:0]  i_sclX;
  logic        i_swpX;
  logic [19:0] i_bcolor;
  logic [31:0] i_colors;
  logic        push_ready, o_valid, o_swpX, full, empty, overflow;
  logic [8:0]  o_posX;
  logic [3:0]  o_sclX;
  logic [19:0] o_bcolor;
  logic [31:0] o_colors;
  logic [3:0]  count;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  sprite_shift_chain #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .push(push), .pop(pop), .rot(rot),
    .i_posX(i_posX), .i_sclX(i_sclX), .i_swpX(i_swpX),
    .i_bcolor(i_bcolor), .i_colors(i_colors),
    .push_ready(push_ready), .o_valid(o_valid),
    .o_posX(o_posX), .o_sclX(o_sclX), .o_swpX(o_swpX),
    .o_bcolor(o_bcolor), .o_colors(o_colors),
    .count(count), .full(full), .empty(empty), .overflow(overflow)
  );

  localparam desc_t A = '{swpX: 1'b1, sclX: 4'd3, posX: 9'h0A5,
                          bcolor: {5'd1, 5'd2, 5'd3, 5'd4}, colors: 32'hDEADBEEF};

  function automatic desc_t mk(input int n);
    desc_t d;
    d.swpX   = n[0];
    d.sclX   = 4'(n);
    d.posX   = 9'(n * 7 + 5);
    d.bcolor = {5'(n), 5'(n + 1), 5'(n + 2), 5'(n + 3)};
    d.colors = 32'hC0DE0000 | 32'(n);
    return d;
  endfunction

  // Observable state: valid, head descriptor, count, full, empty, overflow.
  function automatic logic [73:0] obs();
    return {o_valid, o_swpX, o_sclX, o_posX, o_bcolor, o_colors,
            count, full, empty, overflow};
  endfunction

  function automatic logic [73:0] want(input logic v, input desc_t d,
                                       input int c, input logic ovf);
    return {v, d, 4'(c), (c == 8), (c == 0), ovf};
  endfunction

  task automatic idle();
    rst = 0; clr = 0; push = 0; pop = 0; rot = 0;
  endtask

  task automatic drive(input desc_t d);
    i_swpX = d.swpX; i_sclX = d.sclX; i_posX = d.posX;
    i_bcolor = d.bcolor; i_colors = d.colors;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_all();
    idle(); clr = 1; tick(); idle();
  endtask

  task automatic test_reset();
    logic [73:0] e;
    idle(); rst = 1; push = 1; drive(A); tick(); idle();
    e = want(0, '0, 0, 0);
    vecs++;
    if (obs() !== e) begin errs++; $display("FAIL reset_state got %h want %h", obs(), e); end
    vecs++;
    if (push_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %b want 1", push_ready); end
  endtask

  task automatic test_push_one();
    logic [73:0] e;
    idle(); push = 1; drive(A); tick(); idle();
    e = want(1, A, 1, 0);
    vecs++;
    if (obs() !== e) begin errs++; $display("FAIL push_one got %h want %h", obs(), e); end
    flush_all();
  endtask

  task automatic test_fill_drain();
    logic [73:0] e;
    for (int k = 1; k <= 8; k++) begin
      idle(); push = 1; drive(mk(k)); tick();
    end
    idle();
    e = want(1, mk(1), 8, 0);
    vecs++;
    if (obs() !== e) begin errs++; $display("FAIL fill8 got %h want %h", obs(), e); end
    push = 1; drive(mk(9)); #1;
    vecs++;
    if (push_ready !== 1'b0) begin errs++; $display("FAIL full_ready got %b want 0", push_ready); end
    tick(); idle();
    e = want(1, mk(1), 8, 1);
    vecs++;
    if (obs() !== e) begin errs++; $display("FAIL push_on_full got %h want %h", obs(), e); end
    for (int k = 1; k <= 8; k++) begin
      pop = 1; tick(); idle();
      e = (k < 8) ? want(1, mk(k + 1), 8 - k, 1) : want(0, '0, 0, 1);
      vecs++;
      if (obs() !== e) begin errs++; $display("FAIL drain_%0d got %h want %h", k, obs(), e); end
    end
    flush_all();
  endtask

  task automatic test_push_pop_full();
    logic [73:0] e;
    for (int k = 11; k <= 18; k++) begin
      idle(); push = 1; drive(mk(k)); tick();
    end
    idle(); push = 1; pop = 1; drive(mk(30)); #1;
    vecs++;
    if (push_ready !== 1'b1) begin errs++; $display("FAIL pp_ready got %b want 1", push_ready); end
    tick(); idle();
    e = want(1, mk(12), 8, 0);
    vecs++;
    if (obs() !== e) begin errs++; $display("FAIL pp_full got %h want %h", obs(), e); end
    for (int j = 1; j <= 7; j++) begin
      pop = 1; tick(); idle();
      e = (j < 7) ? want(1, mk(12 + j), 8 - j, 0) : want(1, mk(30), 1, 0);
      vecs++;
      if (obs() !== e) begin errs++; $display("FAIL pp_pop_%0d got %h want %h", j, obs(), e); end
    end
    flush_all();
  endtask

  task automatic test_rotate();
    logic [73:0] e;
    desc_t seq [3];
    seq[0] = mk(42); seq[1] = mk(43); seq[2] = mk(41);
    for (int k = 41; k <= 43; k++) begin
      idle(); push = 1; drive(mk(k)); tick();
    end
    idle(); rot = 1; push = 1; drive(mk(50)); #1;
    vecs++;
    if (push_ready !== 1'b0) begin errs++; $display("FAIL rot_ready got %b want 0", push_ready); end
    for (int r = 0; r < 3; r++) begin
      tick(); push = 0;
      e = want(1, seq[r], 3, 1);
      vecs++;
      if (obs() !== e) begin errs++; $display("FAIL rot_%0d got %h want %h", r, obs(), e); end
    end
    flush_all();
  endtask

  task automatic test_clear_mid();
    logic [73:0] e;
    for (int pass = 0; pass < 2; pass++) begin
      idle(); rot = 1; push = 1; drive(mk(60)); tick(); idle();
      e = want(0, '0, 0, 1);
      vecs++;
      if (obs() !== e) begin errs++; $display("FAIL rot_empty_%0d got %h want %h", pass, obs(), e); end
      for (int k = 61; k <= 65; k++) begin
        push = 1; drive(mk(k)); tick();
      end
      idle();
      e = want(1, mk(61), 5, 1);
      vecs++;
      if (obs() !== e) begin errs++; $display("FAIL five_%0d got %h want %h", pass, obs(), e); end
      if (pass == 0) clr = 1; else rst = 1;
      push = 1; pop = 1; drive(mk(70)); tick(); idle();
      e = want(0, '0, 0, 0);
      vecs++;
      if (obs() !== e) begin errs++; $display("FAIL flush_%0d got %h want %h", pass, obs(), e); end
    end
  endtask

  task automatic test_empty_pop();
    logic [73:0] e;
    idle(); pop = 1; tick(); idle();
    e = want(0, '0, 0, 0);
    vecs++;
    if (obs() !== e) begin errs++; $display("FAIL pop_empty got %h want %h", obs(), e); end
    push = 1; pop = 1; drive(mk(80)); #1;
    vecs++;
    if (push_ready !== 1'b1) begin errs++; $display("FAIL pp_empty_ready got %b want 1", push_ready); end
    tick(); idle();
    e = want(1, mk(80), 1, 0);
    vecs++;
    if (obs() !== e) begin errs++; $display("FAIL pp_empty got %h want %h", obs(), e); end
    flush_all();
  endtask

  initial begin
    idle(); rst = 1; drive('0);
    test_reset();
    test_push_one();
    test_fill_drain();
    test_push_pop_full();
    test_rotate();
    test_clear_mid();
    test_empty_pop();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
